// File: rtl/bram_frame_player_if.sv
// Stream and BRAM read bus of the frame player.
// master: the player (drives the BRAM read port and the output stream).
// slave:  the BRAM plus downstream consumer side.
interface bram_frame_player_if #(
  parameter int DATA_W = 40,
  parameter int ADDR_W = 13
);
  logic              bram_en;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_dout;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  modport master (
    output bram_en, bram_addr, m_data, m_valid, m_last,
    input  bram_dout, m_ready
  );

  modport slave (
    input  bram_en, bram_addr, m_data, m_valid, m_last,
    output bram_dout, m_ready
  );
endinterface

// File: rtl/bram_frame_player.sv
// BRAM frame playback engine for the FFT input path.
// Reads FRAME_LEN words starting at BASE_ADDR from a 1-cycle-latency BRAM and
// streams them out with valid/ready and a last-sample flag. Supports one-shot
// and continuous loop playback, stop requests and downstream backpressure.
// Optional: define BRAM_FRAME_PLAYER_FRAME_CNT_EN to add the frame_cnt output
// (completed-frame counter, cleared on each accepted start).
module bram_frame_player #(
  parameter int DATA_W    = 40,
  parameter int ADDR_W    = 13,
  parameter int FRAME_LEN = 8192,
  parameter int BASE_ADDR = 0
) (
  input  logic clka,
  input  logic rst,
  input  logic start,
  input  logic loop_mode,
  input  logic stop,
  output logic busy,
`ifdef BRAM_FRAME_PLAYER_FRAME_CNT_EN
  output logic [15:0] frame_cnt,
`endif
  bram_frame_player_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
  logic              loop_q;
  logic              stop_pend_q;
  logic              vld_p1;
  logic              last_p1;

  logic [DATA_W-1:0] mem_data [2];
  logic              mem_last [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        cnt_q;

  logic              issue, push, pop, accept, frame_end;
  logic [2:0]        credit;

  // Issue rule, next-state and read-index update.
  // The FIFO slot freed by this cycle's pop is credited before deciding to
  // issue; otherwise a read would be throttled every other cycle and a
  // sample-per-cycle stream could not be sustained.
  always_comb begin
    push      = vld_p1;
    pop       = (cnt_q != 2'd0) && bus.m_ready;
    credit    = {1'b0, cnt_q} - {2'b00, pop} + {2'b00, vld_p1};
    issue     = (state_q == RUN) && (credit < 3'd2);
    frame_end = issue && (rd_idx_q == LAST_IDX);
    state_d   = state_q;
    rd_idx_d  = rd_idx_q;
    accept    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          rd_idx_d = '0;
          accept   = 1'b1;
        end
      end
      RUN: begin
        if (frame_end) begin
          rd_idx_d = '0;
          if (!loop_q || stop_pend_q || stop) state_d = DRAIN;
        end else if (issue) begin
          rd_idx_d = rd_idx_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (credit == 3'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p0 -> p1: control state and the read-in-flight tag.
  always_ff @(posedge clka) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_idx_q    <= '0;
      loop_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      vld_p1      <= 1'b0;
      last_p1     <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_idx_q <= rd_idx_d;
      if (accept) loop_q <= loop_mode;
      if (state_q != RUN) stop_pend_q <= 1'b0;
      else if (stop)      stop_pend_q <= 1'b1;
      vld_p1  <= issue;
      last_p1 <= frame_end;
    end
  end

  // Stage p1 -> output: 2-deep FIFO capturing BRAM data with its last tag.
  always_ff @(posedge clka) begin
    if (rst) begin
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      cnt_q       <= 2'd0;
      mem_data[0] <= '0;
      mem_data[1] <= '0;
      mem_last[0] <= 1'b0;
      mem_last[1] <= 1'b0;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= bus.bram_dout;
        mem_last[wr_ptr] <= last_p1;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

`ifdef BRAM_FRAME_PLAYER_FRAME_CNT_EN
  // Count frames whose last sample has been handed downstream.
  always_ff @(posedge clka) begin
    if (rst || accept)                frame_cnt <= 16'd0;
    else if (pop && mem_last[rd_ptr]) frame_cnt <= frame_cnt + 16'd1;
  end
`endif

  assign bus.bram_en   = issue;
  assign bus.bram_addr = BASE_A + rd_idx_q;
  assign bus.m_valid   = (cnt_q != 2'd0);
  assign bus.m_data    = mem_data[rd_ptr];
  assign bus.m_last    = mem_last[rd_ptr];
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_bram_frame_player.sv
// Testbench for bram_frame_player: FRAME_LEN=16, BASE_ADDR=4, BRAM word = address.
module tb_bram_frame_player;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int FL = 16;
  localparam int BA = 4;

  logic clka = 1'b0;
  logic rst, start, loop_mode, stop, busy;
`ifdef BRAM_FRAME_PLAYER_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int checks = 0;
  int errors = 0;

  bram_frame_player_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  bram_frame_player #(.DATA_W(DW), .ADDR_W(AW), .FRAME_LEN(FL), .BASE_ADDR(BA)) dut (
    .clka      (clka),
    .rst       (rst),
    .start     (start),
    .loop_mode (loop_mode),
    .stop      (stop),
    .busy      (busy),
`ifdef BRAM_FRAME_PLAYER_FRAME_CNT_EN
    .frame_cnt (frame_cnt),
`endif
    .bus       (bus.master)
  );

  always #5 clka = ~clka;

  // BRAM model: 1-cycle read latency, word content equals its address.
  always_ff @(posedge clka) begin
    if (bus.bram_en) bus.bram_dout <= DW'(bus.bram_addr);
  end

  typedef struct {
    logic          start;
    logic          stop;
    logic          lp;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
    logic          exp_last;
    logic          exp_busy;
    logic          exp_en;
    logic [AW-1:0] exp_addr;
  } vec_t;

  vec_t vec [21];

  task automatic step();
    @(posedge clka);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Apply the per-cycle table; each row is driven, clocked, then checked.
  task automatic run_table(input string tag);
    for (int r = 0; r < 21; r++) begin
      start = vec[r].start;
      stop = vec[r].stop;
      loop_mode = vec[r].lp;
      step();
      chk({tag, "_valid"}, 32'(bus.m_valid), 32'(vec[r].exp_valid));
      chk({tag, "_busy"}, 32'(busy), 32'(vec[r].exp_busy));
      chk({tag, "_en"}, 32'(bus.bram_en), 32'(vec[r].exp_en));
      chk({tag, "_addr"}, 32'(bus.bram_addr), 32'(vec[r].exp_addr));
      if (vec[r].exp_valid) begin
        chk({tag, "_data"}, 32'(bus.m_data), 32'(vec[r].exp_data));
        chk({tag, "_last"}, 32'(bus.m_last), 32'(vec[r].exp_last));
      end
    end
    start = 1'b0;
    stop = 1'b0;
    loop_mode = 1'b0;
  endtask

  // Start a run and follow it: checks every transfer against the expected
  // sequence, output stability while stalled, address range and FIFO depth.
  task automatic run_collect(input bit lp, input int stop_at, input int ready_pct,
                             input int abort_at, output int n, output int first_c,
                             output int last_c);
    bit pv, pr, sent, done, rdy;
    logic [DW-1:0] pd;
    logic pl;
    n = 0; first_c = -1; last_c = -1;
    pv = 1'b0; pr = 1'b1; sent = 1'b0; done = 1'b0; pd = '0; pl = 1'b0;
    start = 1'b1; loop_mode = lp; stop = 1'b0; bus.m_ready = 1'b1;
    step();
    start = 1'b0; loop_mode = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      stop = 1'b0;
      if (!busy || n == abort_at) begin
        done = 1'b1;
        break;
      end
      if (pv && !pr) begin
        chk("stall_valid", 32'(bus.m_valid), 32'd1);
        chk("stall_data", 32'(bus.m_data), 32'(pd));
        chk("stall_last", 32'(bus.m_last), 32'(pl));
      end
      if (bus.bram_en)
        chk("addr_range", 32'((32'(bus.bram_addr) >= BA) && (32'(bus.bram_addr) <= BA + FL - 1)), 32'd1);
      chk("fifo_depth", 32'(dut.cnt_q <= 2'd2), 32'd1);
      rdy = ($urandom_range(0, 99) < ready_pct);
      bus.m_ready = rdy;
      if (bus.m_valid && rdy) begin
        chk("xfer_data", 32'(bus.m_data), 32'(BA + n % FL));
        chk("xfer_last", 32'(bus.m_last), 32'((n % FL) == FL - 1));
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
        n++;
      end
      if (n == stop_at && !sent) begin
        stop = 1'b1;
        sent = 1'b1;
      end
      pv = bus.m_valid; pr = rdy; pd = bus.m_data; pl = bus.m_last;
      step();
    end
    stop = 1'b0;
    bus.m_ready = 1'b1;
    chk("collect_done", 32'(done), 32'd1);
  endtask

  int n, fc, lc;

  initial begin
    rst = 1'b1; start = 1'b0; loop_mode = 1'b0; stop = 1'b0; bus.m_ready = 1'b1;
    repeat (3) step();
    chk("rst_en", 32'(bus.bram_en), 32'd0);
    chk("rst_addr", 32'(bus.bram_addr), 32'(BA));
    chk("rst_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_last", 32'(bus.m_last), 32'd0);
    chk("rst_data", 32'(bus.m_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
`ifdef BRAM_FRAME_PLAYER_FRAME_CNT_EN
    chk("rst_fcnt", 32'(frame_cnt), 32'd0);
`endif
    rst = 1'b0;
    step();

    // One-shot frame: row 0 starts, row 6 is an ignored start during RUN,
    // row 19 is an ignored stop in IDLE.
    for (int r = 0; r < 21; r++) begin
      vec[r].start     = (r == 0) || (r == 6);
      vec[r].stop      = (r == 19);
      vec[r].lp        = 1'b0;
      vec[r].exp_valid = (r >= 2) && (r <= 17);
      vec[r].exp_data  = DW'(BA + r - 2);
      vec[r].exp_last  = (r == 17);
      vec[r].exp_busy  = (r <= 17);
      vec[r].exp_en    = (r <= 15);
      vec[r].exp_addr  = (r <= 15) ? AW'(BA + r) : AW'(BA);
    end
    run_table("oneshot");

    // Start and stop together in IDLE: start wins, full frame.
    vec[0].stop = 1'b1;
    run_table("startstop");
    vec[0].stop = 1'b0;

    // Loop mode, stop during the second frame: 32 gapless transfers.
    run_collect(1'b1, 20, 100, -1, n, fc, lc);
    chk("loop_count", 32'(n), 32'd32);
    chk("loop_gapless", 32'(lc - fc), 32'd31);
    chk("loop_idle", 32'(busy), 32'd0);
    step();

    // Random backpressure, one-shot.
    run_collect(1'b0, -1, 50, -1, n, fc, lc);
    chk("bp_count", 32'(n), 32'd16);
    step();

    // Reset after 7 transfers, then a clean replay.
    run_collect(1'b0, -1, 100, 7, n, fc, lc);
    chk("abort_count", 32'(n), 32'd7);
    rst = 1'b1;
    step();
    chk("abort_valid", 32'(bus.m_valid), 32'd0);
    chk("abort_addr", 32'(bus.bram_addr), 32'(BA));
    chk("abort_en", 32'(bus.bram_en), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    step();
    chk("abort_quiet", 32'(bus.m_valid), 32'd0);
    run_collect(1'b0, -1, 100, -1, n, fc, lc);
    chk("replay_count", 32'(n), 32'd16);
    step();

    // Loop of three frames then stop.
    run_collect(1'b1, 40, 100, -1, n, fc, lc);
    chk("loop3_count", 32'(n), 32'd48);
`ifdef BRAM_FRAME_PLAYER_FRAME_CNT_EN
    chk("fcnt_three", 32'(frame_cnt), 32'd3);
    start = 1'b1; loop_mode = 1'b0;
    step();
    start = 1'b0;
    chk("fcnt_cleared", 32'(frame_cnt), 32'd0);
    for (int i = 0; i < 40 && busy; i++) step();
    chk("fcnt_busy_end", 32'(busy), 32'd0);
    chk("fcnt_one", 32'(frame_cnt), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
